// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer-phase state encoding used by the master and the APB slaves' bench.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_master.sv
// APB initiator: turns a valid/ready request into SETUP/ACCESS transfers and a one-cycle response.
// Optional ACCESS wait-state timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              prstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e state, state_d;
  logic       accept;
  logic       done;
  logic       timeout;

  // Gating with prstn keeps the port from advertising readiness during the reset cycle.
  assign req_ready = prstn && (state == APB_IDLE);
  assign accept    = req_valid && req_ready;
  assign done      = (state == APB_ACCESS) && pready;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge pclk) begin
    if (!prstn) begin
      wait_cnt <= '0;
    end else if (state != APB_ACCESS) begin
      wait_cnt <= '0;
    end else if (!pready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Fires on the last permitted wait cycle; pready in that same cycle completes normally instead.
  assign timeout = (state == APB_ACCESS) && !pready &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic timeout_cycles_unused;
  assign timeout_cycles_unused = (TIMEOUT_CYCLES > 0);
  assign timeout               = 1'b0;
`endif

  always_comb begin
    state_d = state;
    unique case (state)
      APB_IDLE:   if (accept) state_d = APB_SETUP;
      APB_SETUP:  state_d = APB_ACCESS;
      APB_ACCESS: if (done || timeout) state_d = APB_IDLE;
      default:    state_d = APB_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!prstn) begin
      state     <= APB_IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      psel      <= (state_d != APB_IDLE);
      penable   <= (state_d == APB_ACCESS);
      rsp_valid <= done || timeout;
      rsp_err   <= (done && pslverr) || timeout;
      // Read data is only returned for clean read completions.
      rsp_rdata <= (done && !pwrite && !pslverr) ? prdata : '0;
      if (accept) begin
        paddr  <= req_addr;
        pwrite <= req_write;
        pwdata <= req_write ? req_wdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: expected responses are queued at issue and checked by a monitor.
module tb_apb_master;

  logic        pclk = 1'b0;
  logic        prstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  apb_master #(.ADDR_W(4), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .pclk(pclk), .prstn(prstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest queued expectation.
  always @(negedge pclk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        chk("rsp_cycle", cyc, e.cyc);
        chk("rsp_req_ready", {31'b0, req_ready}, 32'd1);
      end
    end
  end

  // Entered and left at a negedge; nwait = ACCESS cycles with pready low before completion.
  task automatic xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                      input int nwait, input logic [31:0] rd, input logic err,
                      input logic wait_err, input bit hold, output int acc);
    exp_t e;
    int   tries;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    pready = 1'b0; pslverr = 1'b0;
    tries = 0;
    while (req_ready !== 1'b1 && tries < 20) begin
      @(negedge pclk);
      tries++;
    end
    if (req_ready !== 1'b1) begin
      chk("accept_timeout", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc     = cyc + 1;
    e.rdata = (w || err) ? 32'h0 : rd;
    e.err   = err;
    e.cyc   = acc + 2 + nwait;
    sb.push_back(e);
    @(negedge pclk);
    if (!hold) req_valid = 1'b0;
    // Garbage on the slave side during SETUP must not affect the transfer.
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF0000;
    chk("setup_psel", {31'b0, psel}, 32'd1);
    chk("setup_penable", {31'b0, penable}, 32'd0);
    chk("setup_paddr", {28'b0, paddr}, {28'b0, a});
    chk("setup_pwrite", {31'b0, pwrite}, {31'b0, w});
    chk("setup_pwdata", pwdata, w ? d : 32'h0);
    for (int i = 0; i <= nwait; i++) begin
      @(negedge pclk);
      pready  = (i == nwait);
      pslverr = (i == nwait) ? err : wait_err;
      prdata  = (i == nwait) ? rd : 32'hBAD0BAD0;
      chk("access_psel", {31'b0, psel}, 32'd1);
      chk("access_penable", {31'b0, penable}, 32'd1);
      chk("access_paddr", {28'b0, paddr}, {28'b0, a});
      chk("access_pwdata", pwdata, w ? d : 32'h0);
    end
    @(negedge pclk);
    pready = 1'b0; pslverr = 1'b0;
    chk("done_psel", {31'b0, psel}, 32'd0);
    chk("done_penable", {31'b0, penable}, 32'd0);
    chk("hold_paddr", {28'b0, paddr}, {28'b0, a});
    chk("hold_pwrite", {31'b0, pwrite}, {31'b0, w});
  endtask

  int n1, n2;

  initial begin
    prstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 4'h0; req_wdata = 32'h0;
    prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(negedge pclk);
    chk("rst_psel", {31'b0, psel}, 32'd0);
    chk("rst_penable", {31'b0, penable}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_paddr", {28'b0, paddr}, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    prstn = 1'b1;
    @(negedge pclk);
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    xfer(1'b1, 4'h4, 32'hDEADBEEF, 0, 32'h0, 1'b0, 1'b0, 1'b0, n1);
    @(negedge pclk);
    xfer(1'b0, 4'h0, 32'h5A5A5A5A, 3, 32'h12345678, 1'b0, 1'b0, 1'b0, n1);
    @(negedge pclk);
    xfer(1'b1, 4'h8, 32'hCAFEF00D, 1, 32'h77777777, 1'b1, 1'b1, 1'b0, n1);
    @(negedge pclk);
    xfer(1'b1, 4'hC, 32'h11223344, 2, 32'h0, 1'b0, 1'b1, 1'b0, n1);
    @(negedge pclk);

    xfer(1'b1, 4'h2, 32'hAAAA5555, 0, 32'h0, 1'b0, 1'b0, 1'b1, n1);
    xfer(1'b0, 4'h6, 32'h13572468, 1, 32'h0BADCAFE, 1'b0, 1'b0, 1'b0, n2);
    chk("b2b_setup_cycle", n2, n1 + 3);
    @(negedge pclk);

    // Reset while waiting in ACCESS abandons the transfer without a response.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'hA; req_wdata = 32'h0;
    chk("mid_rst_idle", {31'b0, req_ready}, 32'd1);
    @(negedge pclk);
    req_valid = 1'b0;
    @(negedge pclk);
    chk("mid_rst_in_access", {31'b0, penable}, 32'd1);
    prstn = 1'b0;
    @(negedge pclk);
    chk("mid_rst_psel", {31'b0, psel}, 32'd0);
    chk("mid_rst_penable", {31'b0, penable}, 32'd0);
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd0);
    prstn = 1'b1;
    @(negedge pclk);
    chk("mid_rst_release_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_rst_release_rsp", {31'b0, rsp_valid}, 32'd0);

`ifdef APB_MASTER_TIMEOUT_EN
    begin
      exp_t e;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 4'hC;
      pready = 1'b0;
      chk("to_idle", {31'b0, req_ready}, 32'd1);
      e.rdata = 32'h0; e.err = 1'b1; e.cyc = cyc + 1 + 5;
      sb.push_back(e);
      @(negedge pclk);
      req_valid = 1'b0;
      prdata = 32'h99999999;
      repeat (5) @(negedge pclk);
      chk("to_psel", {31'b0, psel}, 32'd0);
      chk("to_penable", {31'b0, penable}, 32'd0);
      @(negedge pclk);
    end
`endif

    repeat (3) @(negedge pclk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
